// File: rtl/mem_acc_reader_if.sv
// Accumulation-memory read/clear port plus the row stream towards the post-accumulation datapath.
// master = the reader (drives memory addresses and the stream), slave = memory model / downstream.
interface mem_acc_reader_if #(
   parameter int NUM_PE              = 16,
   parameter int ACC_BW              = 32,
   parameter int NUM_LAYER_BW        = 2,
   parameter int MEM_ACC_DEPTH_SL_BW = 7
);
   logic                               rd_en;
   logic [NUM_LAYER_BW-1:0]            addr_layer;
   logic [MEM_ACC_DEPTH_SL_BW-1:0]     addr_rd;
   logic [NUM_PE*ACC_BW-1:0]           mem_dout;
   logic                               wr_en;
   logic [MEM_ACC_DEPTH_SL_BW-1:0]     addr_wr;
   logic [NUM_PE*ACC_BW-1:0]           din;
   logic                               m_valid;
   logic                               m_ready;
   logic [NUM_PE*ACC_BW-1:0]           m_data;
   logic                               m_last;

   modport master (
      output rd_en, addr_layer, addr_rd, wr_en, addr_wr, din, m_valid, m_data, m_last,
      input  mem_dout, m_ready
   );

   modport slave (
      input  rd_en, addr_layer, addr_rd, wr_en, addr_wr, din, m_valid, m_data, m_last,
      output mem_dout, m_ready
   );
endinterface

// File: rtl/mem_acc_reader.sv
// Accumulation-memory drain sequencer: streams rows 0..num_rows-1 of one layer slice; ACC_CLR_EN zeroes each row after it is read.
// First beat 2 clks after start, then 1 row/clk; two read credits cover the BRAM latency so m_ready stalls never drop a row.

module mem_acc_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               pop_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign pop_dat = store[rd_ptr];
endmodule

module mem_acc_reader #(
   parameter int NUM_PE              = 16,
   parameter int ACC_BW              = 32,
   parameter int NUM_LAYER_BW        = 2,
   parameter int MEM_ACC_DEPTH_SL_BW = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [NUM_LAYER_BW-1:0]      layer,
   input  logic [MEM_ACC_DEPTH_SL_BW:0] num_rows,
   output logic                         busy,
   output logic                         done,
   mem_acc_reader_if.master             bus
);
   localparam int DW = NUM_PE*ACC_BW;
   localparam int RW = MEM_ACC_DEPTH_SL_BW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NUM_LAYER_BW-1:0] layer_q;
   logic [RW-1:0]           rows_q;
   logic [RW-1:0]           rd_cnt;
   logic [RW-1:0]           beat_cnt;
   logic                    inflight;
   logic [1:0]              fifo_count;
   logic [DW-1:0]           fifo_head;
   logic [1:0]              occ;
   logic                    fifo_empty;
   logic                    issue;
   logic                    last_issue;
   logic                    xfer;
   logic                    fifo_push;
   logic                    fifo_pop;

   // occ counts every row already owed to the stream: queued plus the one on mem_dout
   assign fifo_empty = (fifo_count == 2'd0);
   assign occ        = fifo_count + {1'b0, inflight};
   assign issue      = (state == RUN) && (rd_cnt < rows_q) && (occ < 2'd2);
   assign last_issue = issue && (rd_cnt == rows_q - 1'b1);

   // An empty FIFO lets the row on mem_dout straight through; if it stalls it is queued instead
   assign bus.m_valid = !fifo_empty || inflight;
   assign xfer        = bus.m_valid && bus.m_ready;
   assign fifo_push   = inflight && !(fifo_empty && bus.m_ready);
   assign fifo_pop    = xfer && !fifo_empty;
   assign bus.m_data  = !fifo_empty ? fifo_head : (inflight ? bus.mem_dout : '0);
   assign bus.m_last  = bus.m_valid && (beat_cnt == rows_q - 1'b1);

   assign bus.rd_en      = issue;
   assign bus.addr_rd    = rd_cnt[MEM_ACC_DEPTH_SL_BW-1:0];
   assign bus.addr_layer = layer_q;

   mem_acc_fifo #(.W(DW), .DEPTH(2)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat (bus.mem_dout),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         layer_q  <= '0;
         rows_q   <= '0;
         rd_cnt   <= '0;
         beat_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (state == IDLE && start) begin
            layer_q  <= layer;
            rows_q   <= num_rows;
            rd_cnt   <= '0;
            beat_cnt <= '0;
         end else if (state == DONE) begin
            rd_cnt   <= '0;
            beat_cnt <= '0;
         end else begin
            if (issue) rd_cnt   <= rd_cnt + 1'b1;
            if (xfer)  beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_issue) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // finish in the clk whose accept empties everything still owed
            if (occ == {1'b0, xfer}) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ACC_CLR_EN
   logic [MEM_ACC_DEPTH_SL_BW-1:0] addr_wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     addr_wr_q <= '0;
      else if (issue) addr_wr_q <= bus.addr_rd;
   end

   // write lands one clk after the read of the same row, so the read always sees old data
   assign bus.wr_en   = inflight;
   assign bus.addr_wr = addr_wr_q;
   assign bus.din     = '0;
`else
   assign bus.wr_en   = 1'b0;
   assign bus.addr_wr = '0;
   assign bus.din     = '0;
`endif
endmodule

// File: tb/tb_mem_acc_reader.sv
// Bench for mem_acc_reader: memory model, directed drains, scoreboard queue checked by a separate monitor.
module tb_mem_acc_reader;
   localparam int DW  = 512;
   localparam int SBW = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] layer = '0;
   logic [7:0] num_rows = '0;
   logic       busy;
   logic       done;

   mem_acc_reader_if #(.NUM_PE(16), .ACC_BW(32), .NUM_LAYER_BW(2), .MEM_ACC_DEPTH_SL_BW(SBW)) bus ();

   mem_acc_reader #(.NUM_PE(16), .ACC_BW(32), .NUM_LAYER_BW(2), .MEM_ACC_DEPTH_SL_BW(SBW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .layer    (layer),
      .num_rows (num_rows),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_mode  = 0;
   int epoch     = 0;
   int exp_layer = 0;
   logic [DW:0] exp_q [$];

   int beats, rds, dones, first_vld, last_beat, done_at, outst;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // lane i of (layer l, row r) = r*16+i, offset by (l-1)<<28 so layer 1 is exactly r*16+i
   function automatic logic [DW-1:0] exp_row(input int l, input int r);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(r*16 + i) + 32'(l - 1) * 32'h1000_0000;
      return v;
   endfunction

   logic [DW-1:0] mem [4][128];
   bit            preload_go = 1'b0;

   always @(posedge clk) begin
      if (preload_go) begin
         for (int l = 0; l < 4; l++)
            for (int r = 0; r < 128; r++) mem[l][r] <= exp_row(l, r);
      end else if (bus.wr_en) begin
         mem[bus.addr_layer][bus.addr_wr] <= bus.din;
      end
      if (bus.rd_en) bus.mem_dout <= mem[bus.addr_layer][bus.addr_rd];
   end

   initial begin : ready_drv
      int ph;
      ph = 0;
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0) bus.m_ready = 1'b1;
         else begin
            bus.m_ready = (ph == 0);
            ph = (ph + 1) % 3;
         end
      end
   end

   initial begin : monitor
      int            my_epoch;
      int            exp_addr;
      bit            pstall;
      bit            prd;
      logic [SBW-1:0] paddr;
      logic [DW-1:0] pdata;
      logic [DW:0]   e;
      my_epoch = 0; exp_addr = 0; pstall = 0; prd = 0; paddr = '0; pdata = '0;
      beats = 0; rds = 0; dones = 0; first_vld = -1; last_beat = -1; done_at = -1; outst = 0;
      forever begin
         @(negedge clk);
         if (epoch != my_epoch) begin
            my_epoch = epoch; exp_addr = 0; pstall = 0; prd = 0;
            beats = 0; rds = 0; dones = 0; first_vld = -1; last_beat = -1; done_at = -1; outst = 0;
         end
         if (pstall) begin
            chk("stall_hold_vld", int'(bus.m_valid), 1);
            chk_dat("stall_hold_dat", bus.m_data, pdata);
         end
         if (bus.rd_en) begin
            chk("addr_rd", int'(bus.addr_rd), exp_addr % 128);
            chk("addr_layer", int'(bus.addr_layer), exp_layer);
            exp_addr++; rds++; outst++;
         end
`ifdef ACC_CLR_EN
         if (prd || bus.wr_en) begin
            chk("wr_en_timing", int'(bus.wr_en), int'(prd));
            if (prd) begin
               chk("addr_wr", int'(bus.addr_wr), int'(paddr));
               chk_dat("din_zero", bus.din, '0);
            end
         end
`else
         if (bus.rd_en) begin
            chk("wr_tied", int'({bus.wr_en, bus.addr_wr}), 0);
            chk_dat("din_tied", bus.din, '0);
         end
`endif
         if (bus.m_valid && first_vld < 0) first_vld = cyc;
         if (bus.m_valid && bus.m_ready) begin
            outst--;
            if (exp_q.size() == 0) chk("extra_beat", beats, -1);
            else begin
               e = exp_q.pop_front();
               chk_dat("m_data", bus.m_data, e[DW-1:0]);
               chk("m_last", int'(bus.m_last), int'(e[DW]));
            end
            beats++; last_beat = cyc;
         end
         if (bus.rd_en) chk("outstanding_le2", int'(outst > 2), 0);
         if (done) begin
            dones++; done_at = cyc;
            chk("busy_in_done", int'(busy), 0);
         end
         pstall = bus.m_valid && !bus.m_ready;
         pdata  = bus.m_data;
         prd    = bus.rd_en;
         paddr  = bus.addr_rd;
      end
   end

   task automatic preload();
      preload_go = 1'b1;
      @(posedge clk); #1;
      preload_go = 1'b0;
   endtask

   task automatic push_exp(input int l, input int n, input bit zeros);
      logic [DW-1:0] d;
      logic          lst;
      for (int r = 0; r < n; r++) begin
         d   = zeros ? '0 : exp_row(l, r);
         lst = (r == n - 1);
         exp_q.push_back({lst, d});
      end
   endtask

   task automatic drain(input int l, input int n, input bit zeros, input int mode);
      int t0, budget;
      rdy_mode = mode;
      push_exp(l, n, zeros);
      exp_layer = l; epoch++;
      layer = 2'(l); num_rows = 8'(n); start = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", int'(busy), int'(n > 0));
      budget = 0;
      while (dones == 0 && budget < n*4 + 20) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("done_seen", int'(dones > 0), 1);
      repeat (3) begin @(posedge clk); #1; end
      chk("done_pulses", dones, 1);
      chk("beats", beats, n);
      chk("reads", rds, n);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("busy_idle", int'(busy), 0);
      if (n > 0) chk("done_after_last", done_at, last_beat + 1);
      else begin
         chk("done_lat_n0", done_at, t0 + 1);
         chk("no_valid_n0", first_vld, -1);
      end
      if (mode == 0 && n > 0) begin
         chk("first_vld_lat", first_vld, t0 + 2);
         chk("last_beat_cyc", last_beat, t0 + 1 + n);
      end
      exp_q.delete();
   endtask

   initial begin : stim
      int budget;
      #12;
      chk("rst_m_valid", int'(bus.m_valid), 0);
      chk("rst_rd_en", int'(bus.rd_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_m_last", int'(bus.m_last), 0);
      chk("rst_wr_en", int'(bus.wr_en), 0);
      chk("rst_addr", int'({bus.addr_layer, bus.addr_rd, bus.addr_wr}), 0);
      chk_dat("rst_m_data", bus.m_data, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      preload(); drain(1, 4, 1'b0, 0);
      preload(); drain(1, 4, 1'b0, 1);
      preload(); drain(0, 0, 1'b0, 0);
      preload(); drain(3, 128, 1'b0, 0);

      // reset in the middle of a 4-row drain
      preload();
      rdy_mode = 0;
      push_exp(1, 4, 1'b0);
      exp_layer = 1; epoch++;
      layer = 2'd1; num_rows = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      budget = 0;
      while (beats < 2 && budget < 40) begin
         @(negedge clk); #1;
         budget++;
      end
      chk("beats_before_rst", beats, 2);
      rst_n = 1'b0; epoch++; exp_q.delete();
      #1;
      chk("midrst_m_valid", int'(bus.m_valid), 0);
      chk("midrst_rd_en", int'(bus.rd_en), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_m_last", int'(bus.m_last), 0);
      chk_dat("midrst_m_data", bus.m_data, '0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("midrst_no_done", dones, 0);
      preload(); drain(1, 4, 1'b0, 0);

`ifdef ACC_CLR_EN
      preload();
      drain(1, 4, 1'b0, 0);
      drain(1, 4, 1'b1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
